branch_predictor: RTL
=====================

# branch_predictor

Gshare direction predictor sitting directly upstream of the branch manager: it receives branch lookups from fetch/decode and registers `pred_taken`, `pred_pc` and `pred_addr` into the branch manager one cycle later. It also takes resolved-branch updates, including the manager's `flush`, to train its 2-bit counters and repair the global history. The block stores direction only; the taken target comes in with the request.

## Interface
- `WordSize`, 32, PC/address width
- `IndexBits`, 5, log2 of pattern-table entries (32 counters)
- `HistBits`, 5, global history length; must satisfy 1 <= HistBits <= IndexBits

- `clk`  in  1  clock, rising edge
- `rstn`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  branch lookup this cycle
- `req_pc`  in  WordSize  PC of the branch
- `req_target`  in  WordSize  taken target of the branch
- `upd_valid`  in  1  resolved branch update this cycle
- `upd_pc`  in  WordSize  PC of the resolved branch
- `upd_ghr`  in  HistBits  history snapshot returned with that branch (`pred_ghr` echoed back)
- `upd_taken`  in  1  actual direction
- `upd_flush`  in  1  misprediction; driven by the branch manager's `flush`
- `pred_valid`  out  1  registered prediction is valid
- `pred_taken`  out  1  predicted direction
- `pred_pc`  out  WordSize  registered `req_pc`
- `pred_addr`  out  WordSize  registered `req_target`
- `pred_ghr`  out  HistBits  history used to form this prediction

## Operation
- **State:**
  - `pht`: 2^IndexBits 2-bit saturating counters; MSB is the taken prediction.
  - `ghr`: HistBits speculative global history; newest outcome in bit 0.
- **Index:**
  - `idx = req_pc[IndexBits+1:2] ^ zext(ghr)`.
  - Update index: `uidx = upd_pc[IndexBits+1:2] ^ zext(upd_ghr)`.
  - `zext` pads with zeros to IndexBits.
- **Lookup** (`req_valid=1`, `upd_flush=0`). At the clock edge:
  - `pred_valid<=1`, `pred_taken<=pht[idx][1]`
  - `pred_pc<=req_pc`, `pred_addr<=req_target`, `pred_ghr<=ghr`
  - `ghr<={ghr[HistBits-2:0], pht[idx][1]}`. When HistBits=1, `ghr<=pht[idx][1]`.
- **No lookup:** `pred_valid<=0`; the other pred outputs hold; `ghr` holds.
- **Update** (`upd_valid=1`):
  - `pht[uidx]` increments if `upd_taken`, otherwise decrements.
  - Saturates at 2'b11 and 2'b00.
- **Repair** (`upd_valid=1` and `upd_flush=1`):
  - `ghr<={upd_ghr[HistBits-2:0], upd_taken}`.
  - Any same-cycle lookup is dropped: `pred_valid<=0`, no speculative shift.
  - `upd_flush` with `upd_valid=0` is ignored.
- **Simultaneous lookup and update:**
  - Without flush, both happen in the same cycle.
  - If `idx==uidx`, the prediction uses the pre-update counter value; the write still lands.
- **Arithmetic:** counters are 2-bit; no wrap. `pred_addr` is passed through unchanged. The branch manager forms `pred_pc+4` itself.

## Timing
- **Reset** (`rstn=0` at a rising edge):
  - All `pht` entries = 2'b01 (weakly not-taken); `ghr=0`.
  - `pred_valid=0`, `pred_taken=0`, `pred_pc=0`, `pred_addr=0`, `pred_ghr=0`.
  - Reset overrides same-cycle lookups and updates.
- **Reset mid-operation:** in-flight speculation and training are discarded. The first edge with `rstn=1` may accept a lookup.
- **Latency:**
  - Lookup to pred outputs: exactly 1 cycle.
  - Update to counter visible to a later lookup: 1 cycle.
  - Repair to `ghr` visible to the next lookup: 1 cycle.
- **Throughput:** one lookup and one update per cycle; no stall or backpressure.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
1. **Reset defaults:**
   - Stimulus: hold `rstn=0` for 2 cycles, release, then issue a lookup with `req_pc=0x100`, `req_target=0x200`.
   - Required next cycle: `pred_valid=1`, `pred_taken=0`, `pred_pc=0x100`, `pred_addr=0x200`, `pred_ghr=0`. `ghr` becomes 0.
2. **Training:**
   - Stimulus: after reset, one update with `upd_pc=0x100`, `upd_ghr=0`, `upd_taken=1`, `upd_flush=0`; then a lookup at `0x100` (idx 0).
   - Required: `pred_taken=1`, and `ghr` becomes 5'b00001.
3. **Saturation:**
   - Stimulus: 4 taken updates to idx 0 (counter 11), then 1 not-taken (counter 10).
   - Required: a lookup at idx 0 predicts taken.
   - Stimulus: 1 more not-taken update (counter 01).
   - Required: a lookup at idx 0 predicts not-taken.
4. **Speculative history:**
   - Stimulus: with idx 0 trained to taken, lookup `0x100` followed back-to-back by lookup `0x104`.
   - Required: the second prediction has `pred_ghr=5'b00001`; its idx is 1^1=0, so it also predicts taken. `ghr` ends at 5'b00011.
5. **Flush repair:**
   - Stimulus: `upd_valid=1`, `upd_flush=1`, `upd_ghr=5'b10110`, `upd_taken=1`, with a same-cycle lookup.
   - Required next cycle: `pred_valid=0` and `ghr=5'b01101`; a following lookup reports `pred_ghr=5'b01101`.
6. **Same-index collision:**
   - Stimulus: idx 0 counter at 01; in one cycle, lookup `0x100` plus a taken update to `0x100` with `upd_ghr=0`.
   - Required: `pred_taken=0` (old value); a lookup at idx 0 on the next cycle sees counter 10 and predicts taken.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Lookup, training and prediction signals between fetch/decode, the gshare
// predictor and the branch manager.
interface branch_predictor_if #(
  parameter int WordSize  = 32,
  parameter int HistBits  = 5
);
  logic                req_valid;
  logic [WordSize-1:0] req_pc;
  logic [WordSize-1:0] req_target;

  logic                upd_valid;
  logic [WordSize-1:0] upd_pc;
  logic [HistBits-1:0] upd_ghr;
  logic                upd_taken;
  logic                upd_flush;

  logic                pred_valid;
  logic                pred_taken;
  logic [WordSize-1:0] pred_pc;
  logic [WordSize-1:0] pred_addr;
  logic [HistBits-1:0] pred_ghr;

  modport master (
    output req_valid, req_pc, req_target,
    output upd_valid, upd_pc, upd_ghr, upd_taken, upd_flush,
    input  pred_valid, pred_taken, pred_pc, pred_addr, pred_ghr
  );

  modport slave (
    input  req_valid, req_pc, req_target,
    input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_flush,
    output pred_valid, pred_taken, pred_pc, pred_addr, pred_ghr
  );
endinterface

// File: rtl/branch_predictor.sv
// Gshare direction predictor: 2-bit counter table indexed by PC xor speculative
// global history, with registered prediction outputs and flush-time history repair.
module branch_predictor #(
  parameter int WordSize  = 32,
  parameter int IndexBits = 5,
  parameter int HistBits  = 5
) (
  input logic               clk,
  input logic               rstn,
  branch_predictor_if.slave bp
);
  localparam int NumEntries = 1 << IndexBits;

  logic [1:0]           pht_q [NumEntries];
  logic [HistBits-1:0]  ghr_q, ghr_d;

  logic                 pred_valid_q, pred_valid_d;
  logic                 pred_taken_q, pred_taken_d;
  logic [WordSize-1:0]  pred_pc_q, pred_pc_d;
  logic [WordSize-1:0]  pred_addr_q, pred_addr_d;
  logic [HistBits-1:0]  pred_ghr_q, pred_ghr_d;

  logic [IndexBits-1:0] idx, uidx;
  logic                 lookup_taken;
  logic                 do_repair, do_lookup;
  logic [1:0]           cnt_cur, cnt_new;
  logic [HistBits-1:0]  spec_hist, repair_hist;

  assign idx          = bp.req_pc[IndexBits+1:2] ^ IndexBits'(ghr_q);
  assign uidx         = bp.upd_pc[IndexBits+1:2] ^ IndexBits'(bp.upd_ghr);
  assign lookup_taken = pht_q[idx][1];
  assign do_repair    = bp.upd_valid & bp.upd_flush;
  assign do_lookup    = bp.req_valid & ~do_repair;
  assign cnt_cur      = pht_q[uidx];

  // A one-bit history is simply the latest outcome; wider ones shift left.
  generate
    if (HistBits == 1) begin : g_hist1
      assign spec_hist   = lookup_taken;
      assign repair_hist = bp.upd_taken;
    end else begin : g_histn
      assign spec_hist   = {ghr_q[HistBits-2:0], lookup_taken};
      assign repair_hist = {bp.upd_ghr[HistBits-2:0], bp.upd_taken};
    end
  endgenerate

  always_comb begin
    cnt_new = cnt_cur;
    if (bp.upd_taken) begin
      if (cnt_cur != 2'b11) cnt_new = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'b00) cnt_new = cnt_cur - 2'd1;
    end
  end

  always_comb begin
    ghr_d        = ghr_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_pc_d    = pred_pc_q;
    pred_addr_d  = pred_addr_q;
    pred_ghr_d   = pred_ghr_q;
    if (do_lookup) begin
      pred_valid_d = 1'b1;
      pred_taken_d = lookup_taken;
      pred_pc_d    = bp.req_pc;
      pred_addr_d  = bp.req_target;
      pred_ghr_d   = ghr_q;
      ghr_d        = spec_hist;
    end
    if (do_repair) begin
      ghr_d = repair_hist;
    end
  end

  // Prediction reads the pre-update counter; a same-cycle training write still lands.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NumEntries; i++) begin
        pht_q[i] <= 2'b01;
      end
    end else if (bp.upd_valid) begin
      pht_q[uidx] <= cnt_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_pc_q    <= '0;
      pred_addr_q  <= '0;
      pred_ghr_q   <= '0;
    end else begin
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_pc_q    <= pred_pc_d;
      pred_addr_q  <= pred_addr_d;
      pred_ghr_q   <= pred_ghr_d;
    end
  end

  assign bp.pred_valid = pred_valid_q;
  assign bp.pred_taken = pred_taken_q;
  assign bp.pred_pc    = pred_pc_q;
  assign bp.pred_addr  = pred_addr_q;
  assign bp.pred_ghr   = pred_ghr_q;

  logic unused_upd_pc;
  assign unused_upd_pc = ^{bp.upd_pc[WordSize-1:IndexBits+2], bp.upd_pc[1:0]};
endmodule
